// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the seven-segment scan driver, its segment ROM and the display pins.
// master = the driver, slave = the ROM/board side.
`timescale 1ns/1ps
interface seg_scan_driver_if;
    logic        page_sel;
    logic        rom_addr;
    logic [63:0] rom_dout;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        page_now;
    logic        frame_done;

    modport master (
        input  page_sel,
        input  rom_dout,
        output rom_addr,
        output seg,
        output an,
        output page_now,
        output frame_done
    );

    modport slave (
        output page_sel,
        output rom_dout,
        input  rom_addr,
        input  seg,
        input  an,
        input  page_now,
        input  frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Fetches a 64-bit packed seven-segment page from ROM once per frame and
// time-multiplexes its 8 bytes onto an 8-digit common-anode display.
`timescale 1ns/1ps
module seg_scan_driver #(
    parameter int unsigned DIV       = 50000,
    parameter int unsigned CNT_W     = 16,
    parameter logic [7:0]  SEG_BLANK = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.master  bus
);
    typedef enum logic [1:0] {
        ST_FETCH1 = 2'd0,
        ST_FETCH2 = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    state_t           r_state;
    logic [2:0]       r_digit;
    logic [CNT_W-1:0] r_presc;
    logic             r_rom_addr;
    logic             r_page_now;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;
    logic             r_frame_done;
    logic [63:0]      r_shadow;

    logic [2:0]       w_digit_nxt;
    logic [5:0]       w_byte_lsb;

    assign w_digit_nxt = r_digit + 3'd1;
    assign w_byte_lsb  = {w_digit_nxt, 3'b000};

    // Outputs come straight from registers; the shadow word isolates the
    // display from ROM changes between fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH1;
            r_digit      <= 3'd0;
            r_presc      <= '0;
            r_rom_addr   <= 1'b0;
            r_page_now   <= 1'b0;
            r_an         <= 8'hFF;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
            r_shadow     <= 64'h0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_FETCH1: begin
                    r_rom_addr <= bus.page_sel;
                    r_an       <= 8'hFF;
                    r_seg      <= SEG_BLANK;
                    r_state    <= ST_FETCH2;
                end
                ST_FETCH2: begin
                    // Digit 0 is loaded straight from the ROM so it lights on the next cycle.
                    r_shadow   <= bus.rom_dout;
                    r_page_now <= r_rom_addr;
                    r_presc    <= '0;
                    r_digit    <= 3'd0;
                    r_an       <= 8'hFE;
                    r_seg      <= bus.rom_dout[7:0];
                    r_state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (r_presc == DIV_LAST) begin
                        r_presc <= '0;
                        if (r_digit != 3'd7) begin
                            r_digit <= w_digit_nxt;
                            r_an    <= ~(8'h01 << w_digit_nxt);
                            r_seg   <= r_shadow[w_byte_lsb +: 8];
                        end else begin
                            // Wrap goes through a fresh fetch, never straight back to digit 0.
                            r_state      <= ST_FETCH1;
                            r_an         <= 8'hFF;
                            r_seg        <= SEG_BLANK;
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_FETCH1;
                    r_an    <= 8'hFF;
                    r_seg   <= SEG_BLANK;
                end
            endcase
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.page_now   = r_page_now;
    assign bus.frame_done = r_frame_done;
endmodule
